// File: rtl/axi4l_master_bridge_if.sv
// rtl/axi4l_master_bridge_if.sv - AXI4-Lite interface bundle used by the bridge
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4l_master_bridge.sv
// rtl/axi4l_master_bridge.sv - core req/gnt/rvalid data port to AXI4-Lite master, one access in flight
module axi4l_master_bridge #(
  parameter int unsigned timeout = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  axi4l_if.master     axi
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RRESP,
    DRAIN
  } state_t;

  state_t      state;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        rready_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_hs;
  logic r_hs;
  logic aw_clear;
  logic w_clear;
  logic b_error;
  logic r_error;
  logic tmo_fire;

  assign aw_hs = awvalid_q && axi.awready;
  assign w_hs  = wvalid_q && axi.wready;
  assign ar_hs = arvalid_q && axi.arready;
  assign b_hs  = bready_q && axi.bvalid;
  assign r_hs  = rready_q && axi.rvalid;

  // True when no AW (resp. W) beat is left outstanding after this cycle
  assign aw_clear = !awvalid_q || axi.awready;
  assign w_clear  = !wvalid_q || axi.wready;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not
  assign b_error = (axi.bresp == 2'b10) || (axi.bresp == 2'b11);
  assign r_error = (axi.rresp == 2'b10) || (axi.rresp == 2'b11);

  assign data_gnt_o = (state == IDLE) && data_req_i;

  assign axi.awaddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  generate
    if (timeout > 0) begin : g_wdog
      localparam int CW = $clog2(timeout + 1) + 1;
      // Counter value seen in the cycle before the error pulse must appear
      localparam logic [CW-1:0] FIRE_AT = (timeout >= 2) ? CW'(timeout - 2) : '0;
      logic [CW-1:0] cnt;
      logic          busy;

      assign busy = (state == WRITE) || (state == WRESP) || (state == READ) || (state == RRESP);

      // Cycles spent waiting on the slave since the grant; saturates rather than wrapping
      always_ff @(posedge clk) begin
        if (reset || data_gnt_o) begin
          cnt <= '0;
        end else if (busy && (cnt != '1)) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign tmo_fire = busy && (cnt >= FIRE_AT);
    end else begin : g_no_wdog
      assign tmo_fire = 1'b0;
    end
  endgenerate

  // Transaction sequencing: capture on grant, drive AXI channels, report completion to the core
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= 1'b0;
      // Valids drop only on their own handshake, also after a timeout
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (data_req_i) begin
            addr_q  <= data_addr_i & 32'hFFFF_FFFC;
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
            we_q    <= data_we_i;
            if (data_we_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state     <= READ;
            end
          end
        end
        WRITE: begin
          if (aw_clear && w_clear) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
          if (tmo_fire) begin
            state         <= DRAIN;
            data_rvalid_o <= 1'b1;
            data_err_o    <= 1'b1;
            data_rdata_o  <= '0;
          end
        end
        WRESP: begin
          if (b_hs) begin
            bready_q      <= 1'b0;
            state         <= IDLE;
            data_rvalid_o <= 1'b1;
            data_err_o    <= b_error;
            data_rdata_o  <= '0;
          end else if (tmo_fire) begin
            state         <= DRAIN;
            data_rvalid_o <= 1'b1;
            data_err_o    <= 1'b1;
            data_rdata_o  <= '0;
          end
        end
        READ: begin
          if (ar_hs) begin
            rready_q <= 1'b1;
            state    <= RRESP;
          end
          if (tmo_fire) begin
            state         <= DRAIN;
            data_rvalid_o <= 1'b1;
            data_err_o    <= 1'b1;
            data_rdata_o  <= '0;
          end
        end
        RRESP: begin
          if (r_hs) begin
            rready_q      <= 1'b0;
            state         <= IDLE;
            data_rvalid_o <= 1'b1;
            data_err_o    <= r_error;
            data_rdata_o  <= axi.rdata;
          end else if (tmo_fire) begin
            state         <= DRAIN;
            data_rvalid_o <= 1'b1;
            data_err_o    <= 1'b1;
            data_rdata_o  <= '0;
          end
        end
        DRAIN: begin
          // The core already got its error; swallow whatever response eventually arrives
          if (we_q) begin
            if ((awvalid_q || wvalid_q) && aw_clear && w_clear) bready_q <= 1'b1;
            if (b_hs) begin
              bready_q <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            if (ar_hs) rready_q <= 1'b1;
            if (r_hs) begin
              rready_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
